prog_rom_arbiter: RTL

- Shares the single-port, 2048x12 synchronous program ROM between two requesters:
  - the CPU instruction-fetch port, which normally has priority;
  - a secondary debug/loader read port, used for program dump and table reads.
- The ROM registers its address on the clock edge and presents data combinationally from that latched address, so read data appears in the cycle after the address is driven.
- The arbiter steers the ROM address, tags each in-flight read with its owner and returns data to the correct requester.
- A starvation counter guarantees the debug port a slot under continuous CPU fetch.

---
 rtl/prog_rom_arbiter_if.sv | 34 +++
 rtl/prog_rom_arbiter.sv | 120 ++++++++++++
 2 files changed

// File: rtl/prog_rom_arbiter_if.sv
// Bus bundle for the program ROM arbiter: CPU fetch port, debug read port and ROM port.
// The slave modport is the arbiter's view; master is the requester/ROM side.
interface prog_rom_arbiter_if #(
   parameter int unsigned ADDR_W = 11,
   parameter int unsigned DATA_W = 12
);
   // CPU instruction-fetch port
   logic              cpu_req;
   logic [ADDR_W-1:0] cpu_addr;
   logic              cpu_stall;
   logic              cpu_valid;
   logic [DATA_W-1:0] cpu_rdata;

   // Debug/loader read port
   logic              dbg_req;
   logic [ADDR_W-1:0] dbg_addr;
   logic              dbg_gnt;
   logic              dbg_valid;
   logic [DATA_W-1:0] dbg_rdata;

   // ROM port
   logic [ADDR_W-1:0] rom_addr;
   logic [DATA_W-1:0] rom_q;

   modport slave (
      input  cpu_req, cpu_addr, dbg_req, dbg_addr, rom_q,
      output cpu_stall, cpu_valid, cpu_rdata, dbg_gnt, dbg_valid, dbg_rdata, rom_addr
   );

   modport master (
      output cpu_req, cpu_addr, dbg_req, dbg_addr, rom_q,
      input  cpu_stall, cpu_valid, cpu_rdata, dbg_gnt, dbg_valid, dbg_rdata, rom_addr
   );
endinterface

// File: rtl/prog_rom_arbiter.sv
// Shares a single-port synchronous program ROM between the CPU fetch port (priority) and a
// debug read port. Each read is tagged with its owner for the return cycle; a saturating
// starvation counter forces one debug slot after STARVE_LIMIT consecutive lost cycles.
module prog_rom_arbiter #(
   parameter int unsigned       ADDR_W       = 11,
   parameter int unsigned       DATA_W       = 12,
   parameter int unsigned       STARVE_LIMIT = 8,
   parameter logic [ADDR_W-1:0] RESET_VECTOR = 11'h7FF
) (
   input logic                i_clock,
   input logic                i_reset,
   prog_rom_arbiter_if.slave  io_bus
);

   localparam logic [7:0] LP_LIMIT = 8'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      StIdle,
      StCpuRd,
      StDbgRd
   } state_e;

   state_e              r_state;
   state_e              w_state_next;
   logic [7:0]          r_starve_cnt;
   logic [7:0]          w_starve_next;
   logic [ADDR_W-1:0]   r_hold_addr;
   logic [DATA_W-1:0]   r_dbg_rdata;
   logic                r_dbg_valid;

   logic                w_force_dbg;
   logic                w_gnt_cpu;
   logic                w_gnt_dbg;
   logic [ADDR_W-1:0]   w_rom_addr;
   logic                w_cpu_valid;
   logic                w_dbg_capture;

   // Grant decision and ROM address steering for the current cycle
   always_comb begin
      w_force_dbg = (STARVE_LIMIT != 0) && (r_starve_cnt == LP_LIMIT) && io_bus.dbg_req;
      w_gnt_cpu   = io_bus.cpu_req && !w_force_dbg;
      w_gnt_dbg   = io_bus.dbg_req && !w_gnt_cpu;
      if (w_gnt_cpu) begin
         w_rom_addr = io_bus.cpu_addr;
      end else if (w_gnt_dbg) begin
         w_rom_addr = io_bus.dbg_addr;
      end else begin
         // Keep the ROM looking at the last granted word when nobody asks
         w_rom_addr = r_hold_addr;
      end
   end

   // Starvation counter next value: counts debug-pending CPU wins, saturates at the limit
   always_comb begin
      w_starve_next = r_starve_cnt;
      if (w_gnt_dbg || !io_bus.dbg_req) begin
         w_starve_next = 8'd0;
      end else if (w_gnt_cpu && (r_starve_cnt != LP_LIMIT)) begin
         w_starve_next = r_starve_cnt + 8'd1;
      end
   end

   // Owner FSM state register
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Owner FSM next state: whoever is granted now owns the data next cycle
   always_comb begin
      w_state_next = StIdle;
      if (w_gnt_cpu) begin
         w_state_next = StCpuRd;
      end else if (w_gnt_dbg) begin
         w_state_next = StDbgRd;
      end
   end

   // Owner FSM outputs: route the returning ROM word
   always_comb begin
      w_cpu_valid   = 1'b0;
      w_dbg_capture = 1'b0;
      unique case (r_state)
         StCpuRd: w_cpu_valid   = 1'b1;
         StDbgRd: w_dbg_capture = 1'b1;
         default: ;
      endcase
   end

   // Counter, held address and debug return registers
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_starve_cnt <= 8'd0;
         r_hold_addr  <= RESET_VECTOR;
         r_dbg_rdata  <= '0;
         r_dbg_valid  <= 1'b0;
      end else begin
         r_starve_cnt <= w_starve_next;
         if (w_gnt_cpu || w_gnt_dbg) begin
            r_hold_addr <= w_rom_addr;
         end
         if (w_dbg_capture) begin
            r_dbg_rdata <= io_bus.rom_q;
         end
         r_dbg_valid <= w_dbg_capture;
      end
   end

   assign io_bus.rom_addr  = w_rom_addr;
   assign io_bus.cpu_stall = io_bus.cpu_req && !w_gnt_cpu;
   assign io_bus.dbg_gnt   = w_gnt_dbg;
   assign io_bus.cpu_valid = w_cpu_valid;
   assign io_bus.cpu_rdata = io_bus.rom_q;
   assign io_bus.dbg_valid = r_dbg_valid;
   assign io_bus.dbg_rdata = r_dbg_rdata;

endmodule
